// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_ctrl_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef logic [2*DIV_DATA_W-1:0] double_reg_t;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake: request/operands in, result/ready/stall out.
interface div_if #(
    parameter int DATA_W = 32
);
    import div_ctrl_pkg::*;

    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration on the packed {rem,quo} register.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] dq_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W-1:0] dq_o
);
    logic [DATA_W:0] minuend;
    logic [DATA_W:0] trial;

    // The bit shifted out of rem is kept as the minuend MSB so divisors
    // above 2^(DATA_W-1) still compare correctly; the top bit of trial is the borrow.
    assign minuend = dq_i[2*DATA_W-1:DATA_W-1];
    assign trial   = minuend - {1'b0, divisor_i};

    always_comb begin
        if (!trial[DATA_W]) begin
            dq_o = {trial[DATA_W-1:0], dq_i[DATA_W-2:0], 1'b1};
        end else begin
            dq_o = {dq_i[2*DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer for DIV/DIVU: one quotient bit per cycle, sign fix-up at the end,
// result held until EX drops start_i.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int                CNT_W   = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   dq_q, dq_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  neg_a_q, neg_a_d;
    logic                  neg_b_q, neg_b_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [2*DATA_W-1:0]   dq_step;
    logic                  neg_a_in, neg_b_in;
    logic [DATA_W-1:0]     opa_mag, opb_mag;
    logic [DATA_W-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

    div_step #(.DATA_W(DATA_W)) u_step (
        .dq_i      (dq_q),
        .divisor_i (dvs_q),
        .dq_o      (dq_step)
    );

    assign neg_a_in = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign neg_b_in = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign opa_mag  = neg_a_in ? -bus.opdata1_i : bus.opdata1_i;
    assign opb_mag  = neg_b_in ? -bus.opdata2_i : bus.opdata2_i;

    // Quotient is negative when signs differ; remainder follows the dividend.
    assign quo_raw = dq_q[DATA_W-1:0];
    assign rem_raw = dq_q[2*DATA_W-1:DATA_W];
    assign quo_fix = (neg_a_q ^ neg_b_q) ? -quo_raw : quo_raw;
    assign rem_fix = neg_a_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        dq_d    = {{DATA_W{1'b0}}, opa_mag};
                        dvs_d   = opb_mag;
                        neg_a_d = neg_a_in;
                        neg_b_d = neg_b_in;
                    end
                end
            end
            DIV_BYZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    dq_d  = dq_step;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DIV_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_END: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
endmodule
